// File: rtl/dmem_responder_if.sv
// Module: dmem_responder_if
// Purpose: request/response bus between the core load/store port and the
//   data-memory responder. One valid/ready handshake carries the request and
//   a separate valid/ready handshake carries the response.
// Signals:
//   req_valid   requester -> responder  request present
//   req_ready   responder -> requester  responder can accept this cycle
//   req_we      requester -> responder  1 = store, 0 = load
//   req_funct3  requester -> responder  RV32I size/sign code
//   req_addr    requester -> responder  byte address
//   req_wdata   requester -> responder  store data, LSB-aligned
//   rsp_valid   responder -> requester  response present
//   rsp_ready   requester -> responder  requester accepts response
//   rsp_rdata   responder -> requester  extended load data, 0 for stores/errors
//   rsp_err     responder -> requester  misaligned, out-of-range or illegal funct3
`timescale 1ns/1ps

interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Requester side (core / testbench)
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Responder side (memory)
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Module: dmem_responder
// Purpose: multi-cycle memory-side responder for the core's load/store port.
//   Accepts one request per handshake, waits WAIT_CYCLES, then performs a
//   byte/half/word access into a word-organised RAM. Loads return data that is
//   sign- or zero-extended according to funct3. Bad requests return rsp_err=1
//   with zero data and never touch the RAM.
// Parameters:
//   DEPTH_WORDS  RAM depth in 32-bit words (power of 2)
//   WAIT_CYCLES  wait states between accept and access (0..15)
// Ports:
//   clk   clock, everything on the rising edge
//   rst   synchronous reset, active-low
//   bus   dmem_responder_if.slave (request and response channels)
`timescale 1ns/1ps

module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;

  // Latched request
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Storage; deliberately never reset
  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic          f3_ok;
  logic          misaligned;
  logic          out_of_range;
  logic          req_err;
  logic [3:0]    byte_en;
  logic [31:0]   wr_word;
  logic [31:0]   merged_word;
  logic [31:0]   ld_data;
  logic          do_write;

  assign word_idx = addr_q[AW+1:2];
  assign lane     = addr_q[1:0];
  assign rd_word  = mem[word_idx];
  assign rd_byte  = 8'(rd_word >> {lane, 3'b000});
  assign rd_half  = 16'(rd_word >> {addr_q[1], 4'b0000});

  // Request legality. BU/HU only make sense for loads; anything with
  // address bits above the RAM window is out of range.
  always_comb begin
    f3_ok      = 1'b0;
    misaligned = 1'b0;
    case (funct3_q)
      3'b000: f3_ok = 1'b1;
      3'b001: begin
        f3_ok      = 1'b1;
        misaligned = addr_q[0];
      end
      3'b010: begin
        f3_ok      = 1'b1;
        misaligned = (lane != 2'b00);
      end
      3'b100: f3_ok = !we_q;
      3'b101: begin
        f3_ok      = !we_q;
        misaligned = addr_q[0];
      end
      default: f3_ok = 1'b0;
    endcase
    out_of_range = |addr_q[31:AW+2];
    req_err      = !f3_ok || misaligned || out_of_range;
  end

  // Store lane enables with the data replicated across lanes, so the enabled
  // lanes simply pick their slice out of wr_word.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wr_word = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata_q[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wr_word = wdata_q;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = byte_en[i] ? wr_word[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  // Load extension: bit 2 of funct3 selects zero-extension
  always_comb begin
    case (funct3_q)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'h000000, rd_byte};
      3'b101:  ld_data = {16'h0000, rd_half};
      default: ld_data = 32'h0;
    endcase
  end

  // A reset asserted in the ACCESS cycle itself also suppresses the write.
  assign do_write = rst && (state == S_ACCESS) && we_q && !req_err;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[word_idx] <= merged_word;
    end
  end

  // Control FSM with registered handshake outputs. WAIT counts the loaded
  // value down to zero and then spends one more cycle before ACCESS, so the
  // response appears WAIT_CYCLES+2 edges after the accept edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      wait_cnt      <= 4'd0;
      we_q          <= 1'b0;
      funct3_q      <= 3'b000;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            we_q          <= bus.req_we;
            funct3_q      <= bus.req_funct3;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            wait_cnt      <= 4'(WAIT_CYCLES);
            bus.req_ready <= 1'b0;
            state         <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_ACCESS;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          bus.rsp_err   <= req_err;
          bus.rsp_rdata <= (req_err || we_q) ? 32'h0 : ld_data;
          bus.rsp_valid <= 1'b1;
          state         <= S_RESP;
        end
        S_RESP: begin
          // A request arriving with rsp_ready waits until IDLE raises req_ready
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Module: tb_dmem_responder
// Purpose: self-checking bench for dmem_responder. Directed load/store,
//   error, backpressure and reset-abort steps followed by a random mix of
//   requests, all compared against a byte-array memory model.
// Ports: none (top level).
`timescale 1ns/1ps

module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITS = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  // Byte-addressed model of RAM contents
  logic [7:0] model_mem [DEPTH*4];

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: size from funct3, little-endian byte gather/scatter
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output logic err);
    int         size;
    logic       legal;
    logic [31:0] v;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
            (!we && ((f3 == 3'd4) || (f3 == 3'd5)));
    err   = !legal || ((addr % 32'(size)) != 0) || ((addr >> 2) >= 32'(DEPTH));
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < size; k++) model_mem[int'(addr) + k] = wdata[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < size; k++) v[8*k +: 8] = model_mem[int'(addr) + k];
        if (!f3[2] && size < 4 && v[8*size-1]) begin
          for (int k = size; k < 4; k++) v[8*k +: 8] = 8'hFF;
        end
        rdata = v;
      end
    end
  endtask

  // One full transaction: accept, latency, optional backpressure, release.
  // Returns the model's expected data for optional extra constant checks.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input int hold, input string tag,
                               output logic [31:0] exp_rdata);
    logic exp_err;
    int   cnt;
    model_access(we, f3, addr, wdata, exp_rdata, exp_err);
    cnt = 0;
    while (bus.req_ready !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    checkOutput({tag, "_accept_timeout"}, 32'(cnt >= 20), 32'd0);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    checkOutput({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
    cnt = 0;
    while (bus.rsp_valid !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1; cnt++;
    end
    checkOutput({tag, "_latency"}, 32'(cnt), 32'(WAITS + 2));
    for (int h = 0; h < hold; h++) begin
      checkOutput({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      checkOutput({tag, "_hold_rdata"}, bus.rsp_rdata, exp_rdata);
      checkOutput({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    checkOutput({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
    checkOutput({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checkOutput({tag, "_valid_clear"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic [2:0]  f3;
    logic [31:0] a;
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;

    // Reset held three cycles, then ready on the first cycle after release
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rel_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rel_rsp_rdata", bus.rsp_rdata, 32'h0);

    // Word store then the various load widths
    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, "sw10", r);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw10", r);
    checkOutput("lw10_const", r, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, 0, "lb13", r);
    checkOutput("lb13_const", r, 32'hFFFFFFDE);
    applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 0, "lbu13", r);
    checkOutput("lbu13_const", r, 32'h000000DE);
    applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, 0, "lh12", r);
    checkOutput("lh12_const", r, 32'hFFFFDEAD);
    applyStimulus(1'b0, 3'b101, 32'h10, 32'h0, 0, "lhu10", r);
    checkOutput("lhu10_const", r, 32'h0000BEEF);

    // Partial stores
    applyStimulus(1'b1, 3'b000, 32'h11, 32'hAABBCC55, 0, "sb11", r);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_after_sb", r);
    checkOutput("lw_after_sb_const", r, 32'hDEAD55EF);
    applyStimulus(1'b1, 3'b001, 32'h12, 32'h00001234, 0, "sh12", r);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_after_sh", r);
    checkOutput("lw_after_sh_const", r, 32'h123455EF);

    // Error cases; the word must survive them
    applyStimulus(1'b0, 3'b010, 32'h11, 32'h0, 0, "err_lw_mis", r);
    applyStimulus(1'b1, 3'b001, 32'h13, 32'h0000AAAA, 0, "err_sh_mis", r);
    applyStimulus(1'b0, 3'b011, 32'h10, 32'h0, 0, "err_f3_011", r);
    applyStimulus(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 0, "err_sbu", r);
    applyStimulus(1'b0, 3'b010, 32'(DEPTH * 4), 32'h0, 0, "err_range", r);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_after_err", r);
    checkOutput("lw_after_err_const", r, 32'h123455EF);

    // Backpressure: response held five cycles
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 5, "bp_lw", r);

    // Reset during WAIT of a store: the store must never land
    applyStimulus(1'b1, 3'b010, 32'h20, 32'h11112222, 0, "sw20", r);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    rst            = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_rst_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_idle_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("abort_no_valid", 32'(bus.rsp_valid), 32'd0);
    end
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 0, "lw20_after_abort", r);
    checkOutput("lw20_const", r, 32'h11112222);

    // Random phase over a pre-filled 64-byte window
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 3'b010, 32'h100 + 32'(4 * i), $urandom, 0, "rnd_fill", r);
    end
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'(DEPTH * 4) + 32'($urandom_range(0, 4095))
                                       : 32'h100 + 32'($urandom_range(0, 63));
      applyStimulus(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom_range(0, 2), "rnd", r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
